// File: rtl/vcu_tiled_mm.sv
// vcu_tiled_mm: tiled signed matrix multiply C = A x B over one shared BRAM.
// Define VCU_SATURATE_EN for wide accumulators with clamped writeback.
module vcu_tiled_mm #(
    parameter int MAX_M  = 16,
    parameter int MAX_N  = 16,
    parameter int WORD   = 32,
    parameter int ADDR_W = 30
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       start,
    input  logic [$clog2(MAX_M+1)-1:0] cfg_m,
    input  logic [$clog2(MAX_N+1)-1:0] cfg_n,
    input  logic [15:0]                cfg_p,
    input  logic [ADDR_W-1:0]          baseA,
    input  logic [ADDR_W-1:0]          baseB,
    input  logic [ADDR_W-1:0]          baseC,
    input  logic [WORD-1:0]            BRAMdataIn,
    output logic [WORD-1:0]            BRAMDataOut,
    output logic [ADDR_W+1:0]          BRAMaddrByte,
    output logic [3:0]                 BRAMWREN,
    output logic                       BRAMENMEM,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int MW = $clog2(MAX_M+1);
    localparam int NW = $clog2(MAX_N+1);
    localparam int RW = $clog2(MAX_M);
    localparam int KW = $clog2(MAX_N);
    localparam int TW = MW + NW;

`ifdef VCU_SATURATE_EN
    localparam int AW = 2*WORD + $clog2(MAX_N);
    localparam int PW = 2*WORD;
    localparam logic signed [AW-1:0] A_HI =
        {{(AW-WORD+1){1'b0}}, {(WORD-1){1'b1}}};
    localparam logic signed [AW-1:0] A_LO =
        {{(AW-WORD+1){1'b1}}, {(WORD-1){1'b0}}};
`else
    localparam int AW = WORD;
    localparam int PW = WORD;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        STREAM_B,
        WRITE_C,
        DONE
    } state_t;

    state_t state;

    logic [MW-1:0]     m_q;
    logic [NW-1:0]     n_q;
    logic [15:0]       p_q;
    logic [15:0]       j;
    logic [ADDR_W-1:0] col_b;
    logic [ADDR_W-1:0] col_c;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     icnt;
    logic [TW-1:0]     tot;
    logic [MW-1:0]     wi;
    logic [RW-1:0]     cr;
    logic [KW-1:0]     ck;
    logic [KW-1:0]     bk;
    logic              rvalid;
    logic              cfg_bad;

    logic signed [WORD-1:0] rf      [MAX_M][MAX_N];
    logic signed [AW-1:0]   acc     [MAX_M];
    logic signed [AW-1:0]   acc_nxt [MAX_M];
    logic signed [PW-1:0]   prod    [MAX_M];

    assign BRAMaddrByte = {addr, 2'b00};
    assign tot = TW'(m_q) * TW'(n_q);
    assign cfg_bad = (cfg_m == '0) || (cfg_m > MW'(MAX_M)) ||
                     (cfg_n == '0) || (cfg_n > NW'(MAX_N)) ||
                     (cfg_p == '0);

    // Convert an accumulator to the word written back to C.
    function automatic logic [WORD-1:0] res_word(
        input logic signed [AW-1:0] a
    );
`ifdef VCU_SATURATE_EN
        if (a > A_HI)
            res_word = {1'b0, {(WORD-1){1'b1}}};
        else if (a < A_LO)
            res_word = {1'b1, {(WORD-1){1'b0}}};
        else
            res_word = a[WORD-1:0];
`else
        res_word = a;
`endif
    endfunction

    // One MAC per active lane for each B word returned in STREAM_B.
    always_comb begin
        for (int r = 0; r < MAX_M; r++) begin
            prod[r] = rf[r][bk] * $signed(BRAMdataIn);
            acc_nxt[r] = acc[r];
            if (state == STREAM_B && rvalid && MW'(r) < m_q)
                acc_nxt[r] = acc[r] + AW'(prod[r]);
        end
    end

    // Capture A words into the row file as they return from BRAM.
    always_ff @(posedge clk) begin
        if (state == LOAD_A && rvalid)
            rf[cr][ck] <= BRAMdataIn;
    end

    // Control FSM; all BRAM and handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= IDLE;
            BRAMDataOut <= '0;
            BRAMWREN    <= '0;
            BRAMENMEM   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            addr        <= '0;
            m_q         <= '0;
            n_q         <= '0;
            p_q         <= '0;
            j           <= '0;
            col_b       <= '0;
            col_c       <= '0;
            icnt        <= '0;
            wi          <= '0;
            cr          <= '0;
            ck          <= '0;
            bk          <= '0;
            rvalid      <= 1'b0;
            for (int r = 0; r < MAX_M; r++)
                acc[r] <= '0;
        end else begin
            done   <= 1'b0;
            error  <= 1'b0;
            rvalid <= BRAMENMEM && (BRAMWREN == 4'b0000);
            for (int r = 0; r < MAX_M; r++)
                acc[r] <= acc_nxt[r];

            if (state == LOAD_A && rvalid) begin
                if (NW'(ck) == n_q - NW'(1)) begin
                    ck <= '0;
                    cr <= cr + RW'(1);
                end else begin
                    ck <= ck + KW'(1);
                end
            end

            if (state == STREAM_B && rvalid)
                bk <= bk + KW'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= cfg_m;
                        n_q   <= cfg_n;
                        p_q   <= cfg_p;
                        col_b <= baseB;
                        col_c <= baseC;
                        if (cfg_bad) begin
                            error <= 1'b1;
                        end else begin
                            state     <= LOAD_A;
                            busy      <= 1'b1;
                            BRAMENMEM <= 1'b1;
                            addr      <= baseA;
                            icnt      <= TW'(1);
                            cr        <= '0;
                            ck        <= '0;
                            j         <= '0;
                        end
                    end
                end

                LOAD_A: begin
                    if (BRAMENMEM) begin
                        if (icnt < tot) begin
                            addr <= addr + ADDR_W'(1);
                            icnt <= icnt + TW'(1);
                        end else begin
                            BRAMENMEM <= 1'b0;
                        end
                    end else begin
                        state     <= STREAM_B;
                        BRAMENMEM <= 1'b1;
                        addr      <= col_b;
                        icnt      <= TW'(1);
                        bk        <= '0;
                        for (int r = 0; r < MAX_M; r++)
                            acc[r] <= '0;
                    end
                end

                STREAM_B: begin
                    if (BRAMENMEM) begin
                        if (icnt < TW'(n_q)) begin
                            addr <= addr + ADDR_W'(1);
                            icnt <= icnt + TW'(1);
                        end else begin
                            BRAMENMEM <= 1'b0;
                        end
                    end else begin
                        state       <= WRITE_C;
                        BRAMENMEM   <= 1'b1;
                        BRAMWREN    <= 4'b1111;
                        addr        <= col_c;
                        BRAMDataOut <= res_word(acc_nxt[0]);
                        wi          <= MW'(1);
                    end
                end

                WRITE_C: begin
                    if (wi < m_q) begin
                        addr        <= col_c + ADDR_W'(wi);
                        BRAMDataOut <= res_word(acc[wi[RW-1:0]]);
                        wi          <= wi + MW'(1);
                    end else begin
                        BRAMWREN    <= 4'b0000;
                        BRAMDataOut <= '0;
                        j           <= j + 16'd1;
                        col_b       <= col_b + ADDR_W'(n_q);
                        col_c       <= col_c + ADDR_W'(m_q);
                        if (j == p_q - 16'd1) begin
                            state     <= DONE;
                            BRAMENMEM <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= STREAM_B;
                            BRAMENMEM <= 1'b1;
                            addr      <= col_b + ADDR_W'(n_q);
                            icnt      <= TW'(1);
                            bk        <= '0;
                            for (int r = 0; r < MAX_M; r++)
                                acc[r] <= '0;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vcu_tiled_mm.md
Name: vcu_tiled_mm

Overview:
- Second-generation vector compute unit: computes C = A x B for runtime-configurable M x N by N x P signed integer matrices held in a shared single-port block RAM.
- Loads A into an internal row register file, streams each B column word by word into MAX_M parallel MAC lanes, then writes each C column back to BRAM.
- Replaces the fixed 16x16 unit; adds a start/done/error handshake, configurable base addresses and dimensions, and wrap/saturate arithmetic selection.

Parameters:
- MAX_M, 16, lane count and maximum rows of A/C
- MAX_N, 16, maximum inner dimension (A row length, B column length)
- WORD, 32, data word width in bits
- ADDR_W, 30, BRAM word-address width

Ports:
- clk  in  1  clock
- RESET  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_m  in  $clog2(MAX_M+1)  rows of A
- cfg_n  in  $clog2(MAX_N+1)  inner dimension
- cfg_p  in  16  columns of B/C
- baseA  in  ADDR_W  word address of A, row-major
- baseB  in  ADDR_W  word address of B, column-major
- baseC  in  ADDR_W  word address of C, column-major
- BRAMdataIn  in  WORD  BRAM read data
- BRAMDataOut  out  WORD  BRAM write data
- BRAMaddrByte  out  ADDR_W+2  byte address = {word_addr, 2'b00}
- BRAMWREN  out  4  byte write enables, 4'b1111 on writes else 0
- BRAMENMEM  out  1  BRAM enable
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: state IDLE; all outputs 0; accumulators, counters and column index cleared. RESET asserted mid-operation aborts immediately, with no further BRAM access and no done.
- BRAM read latency is fixed at 1: address/enable in cycle t, data valid in t+1.
- IDLE: on start, latch cfg_* and base*.
  - If cfg_m==0, cfg_m>MAX_M, cfg_n==0, cfg_n>MAX_N or cfg_p==0: error=1 for one cycle, stay IDLE, no BRAM access.
  - Otherwise go to LOAD_A.
- start while busy is ignored.
- LOAD_A: issue cfg_m*cfg_n consecutive reads from baseA, one per cycle.
  - Word r*cfg_n+k is stored in RF[r][k].
  - The captured word lags its address by one cycle.
  - After the last read, one drain cycle, then go to STREAM_B with j=0.
- STREAM_B: clear all accumulators on entry.
  - Issue cfg_n reads at baseB + j*cfg_n + k, k=0..cfg_n-1.
  - Returned word b_k: lane r (r<cfg_m) does acc[r] += RF[r][k]*b_k, signed. Lanes r>=cfg_m hold 0.
  - One drain cycle for the final word, then go to WRITE_C.
- WRITE_C: cfg_m cycles.
  - Cycle i: BRAMENMEM=1, BRAMWREN=4'b1111, word address baseC + j*cfg_m + i, BRAMDataOut=result(acc[i]).
  - Then j++. If j<cfg_p go to STREAM_B, else go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start in the following cycle is accepted.
- BRAMENMEM is 1 exactly in cycles issuing a read or write; reads and writes never overlap.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and not flagged.
- Total latency from start to done for valid configs: 1 + (M*N+1) + P*(N+1+M) + 1 cycles.
- Arithmetic: products are full 2*WORD signed. Without the optional feature, acc is WORD bits and wraps modulo 2^WORD.

Optional Feature:
- Macro VCU_SATURATE_EN.
- Defined: acc is 2*WORD+$clog2(MAX_N) bits with no overflow. On writeback the result is clamped to [-2^(WORD-1), 2^(WORD-1)-1].
- Undefined: WORD-bit wrapping accumulate and writeback, with no clamp logic.
- Cycle timing is identical in both builds.

Test Plan:
- 2x2 identity: A=[[1,0],[0,1]], B col0=[5,6], col1=[7,8], M=N=P=2, baseC=0x100 -> words 0x100..0x103 = 5,6,7,8; done after 1+5+2*5+1=17 cycles; no error.
- Full size: MAX_M=MAX_N=16, P=3, random signed A and B -> all 48 C words match the reference model; busy high throughout, exactly 48 write cycles.
- Rejected config: start with cfg_n=0, then cfg_m=17 -> error pulse each time, BRAMENMEM stays 0, busy stays 0.
- Overflow: M=N=P=1, A=0x7FFFFFFF, B=2 -> C=0xFFFFFFFE without VCU_SATURATE_EN, 0x7FFFFFFF with it; A=0x80000000, B=2 with macro -> 0x80000000.
- Reset mid-STREAM_B (assert RESET at cycle 8 of a 2x2x2 job) -> next cycle all outputs 0, no done; a fresh start completes correctly.
- Address wrap: baseB=2^ADDR_W-1, N=2 -> reads at 2^ADDR_W-1 then 0; start asserted while busy -> ignored, single done.
